// File: rtl/rot_win_ctrl.sv
// rtl/rot_win_ctrl.sv - windowed rotation-shift tracker with lock detection and adjustment handshake
// Build option: define ROT_WIN_ACK_TIMEOUT_EN to abort adjustments left unacknowledged for 256 cycles
module rot_win_ctrl #(
  parameter int CTR_SIZE = 5,
  parameter int WIN_SIZE = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                stop,
  input  logic [WIN_SIZE-1:0] win_len,
  input  logic [CTR_SIZE-1:0] thr,
  input  logic [CTR_SIZE-1:0] rot_sh,
  input  logic                rot_err,
  output logic                sc_en,
  output logic                sc_timeout,
  output logic                adj_req,
  output logic                adj_dir,
  input  logic                adj_ack,
  output logic                locked,
  output logic                busy,
  output logic [7:0]          err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MEASURE, S_EVAL, S_ADJUST} state_t;

  localparam logic [7:0] LOCK_MAX = 8'(LOCK_CNT);

  state_t              state_q;
  logic [WIN_SIZE-1:0] timer_q;
  logic [CTR_SIZE-1:0] thr_q;
  logic [7:0]          good_q;
  logic [7:0]          err_q;
  logic                sc_en_q, sc_timeout_q, adj_req_q, adj_dir_q, locked_q, busy_q;
`ifdef ROT_WIN_ACK_TIMEOUT_EN
  logic [7:0]          ack_tmr_q;
`endif

  logic [CTR_SIZE-1:0] mag_d;
  logic [WIN_SIZE-1:0] win_load_d;
  logic [7:0]          err_inc_d;
  logic [7:0]          good_inc_d;
  logic                dir_d;

  // The most negative shift wraps back onto itself, which reads as 2^(CTR_SIZE-1) unsigned.
  always_comb begin
    mag_d      = rot_sh[CTR_SIZE-1] ? (~rot_sh + CTR_SIZE'(1)) : rot_sh;
    win_load_d = (win_len < WIN_SIZE'(2)) ? WIN_SIZE'(1) : (win_len - WIN_SIZE'(1));
    err_inc_d  = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);
    good_inc_d = (good_q >= LOCK_MAX) ? good_q : (good_q + 8'd1);
    dir_d      = (rot_sh != '0) && !rot_sh[CTR_SIZE-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      thr_q        <= '0;
      good_q       <= '0;
      err_q        <= '0;
      sc_en_q      <= 1'b0;
      sc_timeout_q <= 1'b0;
      adj_req_q    <= 1'b0;
      adj_dir_q    <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ROT_WIN_ACK_TIMEOUT_EN
      ack_tmr_q    <= '0;
`endif
    end else if (stop) begin
      state_q      <= S_IDLE;
      good_q       <= '0;
      sc_en_q      <= 1'b0;
      sc_timeout_q <= 1'b0;
      adj_req_q    <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_CLEAR;
            sc_en_q      <= 1'b1;
            sc_timeout_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_CLEAR: begin
          thr_q        <= thr;
          timer_q      <= win_load_d;
          state_q      <= S_MEASURE;
          sc_timeout_q <= 1'b0;
        end
        S_MEASURE: begin
          if (rot_err) begin
            err_q        <= err_inc_d;
            good_q       <= '0;
            locked_q     <= 1'b0;
            state_q      <= S_CLEAR;
            sc_timeout_q <= 1'b1;
          end else if (timer_q == '0) begin
            state_q <= S_EVAL;
            sc_en_q <= 1'b0;
          end else begin
            timer_q <= timer_q - WIN_SIZE'(1);
          end
        end
        S_EVAL: begin
          if (mag_d > thr_q) begin
            adj_dir_q <= dir_d;
            good_q    <= '0;
            locked_q  <= 1'b0;
            adj_req_q <= 1'b1;
            state_q   <= S_ADJUST;
`ifdef ROT_WIN_ACK_TIMEOUT_EN
            ack_tmr_q <= '0;
`endif
          end else begin
            good_q       <= good_inc_d;
            locked_q     <= locked_q | (good_inc_d == LOCK_MAX);
            state_q      <= S_CLEAR;
            sc_en_q      <= 1'b1;
            sc_timeout_q <= 1'b1;
          end
        end
        S_ADJUST: begin
          if (adj_ack) begin
            adj_req_q    <= 1'b0;
            state_q      <= S_CLEAR;
            sc_en_q      <= 1'b1;
            sc_timeout_q <= 1'b1;
          end
`ifdef ROT_WIN_ACK_TIMEOUT_EN
          // Counter hits 255 on the 256th requesting cycle.
          else if (ack_tmr_q == 8'hFF) begin
            adj_req_q    <= 1'b0;
            err_q        <= err_inc_d;
            state_q      <= S_CLEAR;
            sc_en_q      <= 1'b1;
            sc_timeout_q <= 1'b1;
          end else begin
            ack_tmr_q <= ack_tmr_q + 8'd1;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sc_en      = sc_en_q;
  assign sc_timeout = sc_timeout_q;
  assign adj_req    = adj_req_q;
  assign adj_dir    = adj_dir_q;
  assign locked     = locked_q;
  assign busy       = busy_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_rot_win_ctrl.sv
// tb/tb_rot_win_ctrl.sv - directed self-checking bench for rot_win_ctrl
module tb_rot_win_ctrl;

  logic        clk;
  logic        rstn;
  logic        start, stop;
  logic [15:0] win_len;
  logic [4:0]  thr, rot_sh;
  logic        rot_err, adj_ack;
  logic        sc_en, sc_timeout, adj_req, adj_dir, locked, busy;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  logic sb_q[$];
  logic adj_prev = 1'b0;

  rot_win_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .win_len(win_len),
    .thr(thr), .rot_sh(rot_sh), .rot_err(rot_err), .sc_en(sc_en),
    .sc_timeout(sc_timeout), .adj_req(adj_req), .adj_dir(adj_dir),
    .adj_ack(adj_ack), .locked(locked), .busy(busy), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sc(output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (!sc_timeout && cyc < 50);
  endtask

  // Each new adjustment request must match the direction queued with the stimulus.
  always @(negedge clk) begin
    if (adj_req && !adj_prev) begin
      if (sb_q.size() == 0) check("adj_unexpected", 32'(adj_req), 32'd0);
      else check("adj_dir", 32'(adj_dir), 32'(sb_q.pop_front()));
    end
    adj_prev = adj_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int hi;
    rstn = 1'b0; start = 1'b0; stop = 1'b0; win_len = 16'd0; thr = 5'd0;
    rot_sh = 5'd0; rot_err = 1'b0; adj_ack = 1'b0;
    step(2);
    check("reset_outs", 32'({sc_en, sc_timeout, adj_req, adj_dir, locked, busy, err_cnt}), 32'd0);

    rstn = 1'b1; win_len = 16'd8; thr = 5'd2; rot_sh = 5'd1; start = 1'b1;
    step(1);
    check("first_clear", 32'({sc_en, sc_timeout, busy}), 32'b111);
    start = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      wait_sc(cyc);
      check("period_w8", 32'(cyc), 32'd10);
      check("locked_w", 32'(locked), 32'(w == 4));
    end

    rot_sh = 5'd5;
    sb_q.push_back(1'b1);
    step(9);
    check("eval_no_req", 32'({adj_req, locked}), 32'b01);
    step(1);
    check("adj_req_up", 32'({adj_req, locked}), 32'b10);
    step(2);
    check("adj_req_hold", 32'(adj_req), 32'd1);
    adj_ack = 1'b1;
    step(1);
    check("ack_clear", 32'({adj_req, sc_timeout}), 32'b01);
    adj_ack = 1'b0;

    rot_sh = 5'b10000; thr = 5'd15;
    sb_q.push_back(1'b0);
    step(10);
    check("neg_max_req", 32'({adj_req, adj_dir}), 32'b10);
    step(2);
    stop = 1'b1;
    step(1);
    check("stop_adjust", 32'({adj_req, busy, sc_en}), 32'd0);
    stop = 1'b0;

    rot_sh = 5'd0; thr = 5'd2; win_len = 16'd8; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int w = 1; w <= 4; w++) wait_sc(cyc);
    check("relock", 32'(locked), 32'd1);
    step(3);
    rot_err = 1'b1;
    step(1);
    check("err_first", 32'({err_cnt, sc_timeout, locked}), 32'({8'd1, 1'b1, 1'b0}));
    step(200);
    check("err_count", 32'(err_cnt), 32'd101);
    step(500);
    rot_err = 1'b0;
    check("err_sat", 32'(err_cnt), 32'd255);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_keeps_err", 32'({err_cnt, busy}), 32'({8'd255, 1'b0}));

    win_len = 16'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_sc(cyc);
    check("period_w0_a", 32'(cyc), 32'd4);
    wait_sc(cyc);
    check("period_w0_b", 32'(cyc), 32'd4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;

    rot_sh = 5'd5; start = 1'b1;
    sb_q.push_back(1'b1);
    step(1);
    start = 1'b0;
    step(4);
    check("pre_reset_req", 32'(adj_req), 32'd1);
    #2 rstn = 1'b0;
    #1 check("async_reset", 32'({adj_req, busy, err_cnt}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    start = 1'b1;
    sb_q.push_back(1'b1);
    step(1);
    start = 1'b0;
    step(4);
    hi = 0;
    while (adj_req && hi < 1100) begin
      step(1);
      hi++;
    end
`ifdef ROT_WIN_ACK_TIMEOUT_EN
    check("ack_timeout_len", 32'(hi), 32'd256);
    check("ack_timeout_err", 32'(err_cnt), 32'd1);
`else
    check("ack_wait_hold", 32'({adj_req, 1'b0}) | 32'(hi > 1000), 32'b11);
    check("ack_wait_err", 32'(err_cnt), 32'd0);
`endif
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rot_win_ctrl.md
ROT_WIN_CTRL -- requirements
Module: rot_win_ctrl

Interface
REQ-001 The block SHALL have parameter CTR_SIZE, default 5, width of the signed rotation shift count (must be >2).
REQ-002 The block SHALL have parameter WIN_SIZE, default 16, width of the measurement window timer.
REQ-003 The block SHALL have parameter LOCK_CNT, default 4, consecutive in-threshold windows required to declare lock (1..255).
REQ-004 The block SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, begin tracking (level or pulse).
REQ-007 The block SHALL have port stop, input, 1, abandon tracking and return to IDLE; priority over start.
REQ-008 The block SHALL have port win_len, input, WIN_SIZE, window length in clk cycles.
REQ-009 The block SHALL have port thr, input, CTR_SIZE, unsigned allowed shift magnitude.
REQ-010 The block SHALL have port rot_sh, input, CTR_SIZE, signed two's-complement shift from the shift counter.
REQ-011 The block SHALL have port rot_err, input, 1, multi-step rotation error from the shift counter.
REQ-012 The block SHALL have port sc_en, output, 1, enable to the shift counter.
REQ-013 The block SHALL have port sc_timeout, output, 1, clear to the shift counter.
REQ-014 The block SHALL have port adj_req, output, 1, adjustment request.
REQ-015 The block SHALL have port adj_dir, output, 1, 1 = captured shift positive, 0 = negative.
REQ-016 The block SHALL have port adj_ack, input, 1, adjustment acknowledge.
REQ-017 The block SHALL have ports locked (output, 1), busy (output, 1, high when state is not IDLE) and err_cnt (output, 8, saturating error count).

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, MEASURE, EVAL and ADJUST.
REQ-019 IDLE SHALL drive sc_en=0 and sc_timeout=0, and SHALL go to CLEAR on start=1 with stop=0.
REQ-020 CLEAR SHALL last one cycle with sc_en=1 and sc_timeout=1, SHALL sample thr and load timer=max(win_len,2)-1, then go to MEASURE.
REQ-021 MEASURE SHALL drive sc_en=1 and sc_timeout=0, and SHALL decrement the timer each cycle; it SHALL go to EVAL in the cycle the timer equals 0, so MEASURE lasts max(win_len,2) cycles.
REQ-022 On rot_err=1 in MEASURE, the block SHALL increment err_cnt (saturating at 255), clear the good-window count, drop locked, and go to CLEAR.
REQ-023 EVAL SHALL drive sc_en=0, capture rot_sh and form mag=|rot_sh| as a CTR_SIZE-bit unsigned value; the most negative value SHALL give mag=2^(CTR_SIZE-1).
REQ-024 In EVAL, when mag>thr, the block SHALL register adj_dir=~rot_sh[MSB] and adj_dir=0 when rot_sh=0, clear the good count, drop locked, and go to ADJUST.
REQ-025 In EVAL, when mag<=thr, the block SHALL increment the good count (saturating at LOCK_CNT), set locked=1 when the count reaches LOCK_CNT, and go to CLEAR.
REQ-026 ADJUST SHALL drive adj_req=1 with adj_dir held stable; on the cycle adj_req and adj_ack are both 1, adj_req SHALL drop next cycle and the state SHALL go to CLEAR; adj_ack outside ADJUST SHALL be ignored.
REQ-027 stop=1 in any state SHALL force IDLE on the next edge, deassert adj_req without waiting for ack, and clear locked and the good count; err_cnt SHALL be retained.
REQ-028 All outputs SHALL be registered; an uninterrupted period without adjustment SHALL be max(win_len,2)+2 cycles.

Reset
REQ-029 On rstn=0, the state SHALL be IDLE and all outputs, timer, good count, captured shift and err_cnt SHALL be 0, asynchronously.
REQ-030 Reset mid-ADJUST SHALL drop adj_req immediately, without waiting for ack.

Configuration
REQ-031 With macro ROT_WIN_ACK_TIMEOUT_EN defined, ADJUST SHALL abort after 256 cycles without ack: adj_req drops, err_cnt increments (saturating), and the state goes to CLEAR.
REQ-032 With ROT_WIN_ACK_TIMEOUT_EN undefined, ADJUST SHALL wait for ack indefinitely; ports are identical in both builds.

Verification
REQ-033 The bench SHALL cover: win_len=8, thr=2, rot_sh=1 constant, start -> sc_timeout pulses every 10 cycles; locked=1 after the 4th EVAL; adj_req never asserted.
REQ-034 The bench SHALL cover: rot_sh=5, thr=2 -> adj_req=1 with adj_dir=1 two cycles after MEASURE ends; ack after 3 cycles -> adj_req drops and CLEAR follows; locked=0.
REQ-035 The bench SHALL cover: rot_sh=-16 (CTR_SIZE=5), thr=15 -> mag=16, adj_dir=0, adjustment requested.
REQ-036 The bench SHALL cover: rot_err pulse at the 3rd MEASURE cycle -> err_cnt increments by 1, CLEAR on the next cycle, locked drops; 300 errors -> err_cnt holds at 255.
REQ-037 The bench SHALL cover: stop during ADJUST with no ack -> IDLE next cycle, adj_req=0, busy=0; win_len=0 -> MEASURE lasts 2 cycles.
REQ-038 The bench SHALL cover: with ROT_WIN_ACK_TIMEOUT_EN defined and ack never given -> adj_req drops after 256 cycles and err_cnt increments; with it undefined -> adj_req stays high for over 1000 cycles.
